// File: rtl/rb2_drain.sv
// rb2_drain: reads the 8-word RB2 result buffer in order and streams it through a 2-entry prefetch FIFO.
// Optional checksum word appended when RB2_DRAIN_CSUM_EN is defined.
module rb2_drain #(
   parameter int unsigned DW = 18,
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          RB2_RW,
   output logic [AW-1:0] RB2_A,
   input  logic [DW-1:0] RB2_Q,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW:0]   out_addr,
   output logic          out_last,
   output logic          busy,
   output logic          done
);
   localparam int unsigned    NW     = 1 << AW;
   localparam logic [AW-1:0]  LAST_A = AW'(NW - 1);
   localparam logic [1:0]     S_IDLE  = 2'd0;
   localparam logic [1:0]     S_READ  = 2'd1;
   localparam logic [1:0]     S_FLUSH = 2'd2;

   logic [1:0]    state, state_nxt;
   logic          start_q, start_edge;
   logic [AW-1:0] rd_cnt, pend_addr;
   logic          rd_pend;
   logic [1:0]    cnt, cnt_nxt;
   logic [DW-1:0] ent1_data;
   logic [AW:0]   ent1_addr;
   logic          ent1_last;
   logic          pop, issue, push, done_nxt;
   logic [2:0]    occ_after;
   logic [DW-1:0] new_data;
   logic [AW:0]   new_addr;
   logic          new_last;
`ifdef RB2_DRAIN_CSUM_EN
   logic [DW-1:0] sum;
   logic          csum_pend, push_cs;
`endif

   assign RB2_RW = 1'b1;
   assign RB2_A  = rd_cnt;

   // Next state; a read is issued only if it still fits after this cycle's pop.
   always_comb begin
      state_nxt  = state;
      done_nxt   = 1'b0;
      issue      = 1'b0;
      start_edge = start & ~start_q;
      pop        = out_valid & out_ready;
      occ_after  = 3'(cnt) + 3'(rd_pend) - 3'(pop);
      case (state)
         S_IDLE:  if (start_edge) state_nxt = S_READ;
         S_READ:  if (occ_after < 3'd2) begin
                     issue = 1'b1;
                     if (rd_cnt == LAST_A) state_nxt = S_FLUSH;
                  end
         S_FLUSH: if (pop && out_last) begin
                     state_nxt = S_IDLE;
                     done_nxt  = 1'b1;
                  end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FIFO push source: SRAM response, or the checksum once word 7 has landed.
   always_comb begin
`ifdef RB2_DRAIN_CSUM_EN
      push_cs  = csum_pend && !(cnt == 2'd2 && !pop);
      push     = rd_pend | push_cs;
      new_data = push_cs ? sum : RB2_Q;
      new_addr = push_cs ? (AW+1)'(NW) : {1'b0, pend_addr};
      new_last = push_cs;
`else
      push     = rd_pend;
      new_data = RB2_Q;
      new_addr = {1'b0, pend_addr};
      new_last = (pend_addr == LAST_A);
`endif
      cnt_nxt = cnt + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Datapath: head entry drives the outputs directly, second entry sits behind it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_q   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_cnt    <= '0;
         pend_addr <= '0;
         rd_pend   <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         ent1_data <= '0;
         ent1_addr <= '0;
         ent1_last <= 1'b0;
`ifdef RB2_DRAIN_CSUM_EN
         sum       <= '0;
         csum_pend <= 1'b0;
`endif
      end else begin
         start_q   <= start;
         busy      <= (state_nxt != S_IDLE);
         done      <= done_nxt;
         rd_pend   <= issue;
         cnt       <= cnt_nxt;
         out_valid <= (cnt_nxt != 2'd0);
         if (issue) begin
            pend_addr <= rd_cnt;
            rd_cnt    <= rd_cnt + AW'(1);
         end
         if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) begin
            out_data <= new_data;
            out_addr <= new_addr;
            out_last <= new_last;
         end else if (pop && cnt == 2'd2) begin
            out_data <= ent1_data;
            out_addr <= ent1_addr;
            out_last <= ent1_last;
         end
         if (push && (cnt == 2'd2 || (cnt == 2'd1 && !pop))) begin
            ent1_data <= new_data;
            ent1_addr <= new_addr;
            ent1_last <= new_last;
         end
`ifdef RB2_DRAIN_CSUM_EN
         if (state == S_IDLE && start_edge) sum <= '0;
         else if (rd_pend)                  sum <= sum + RB2_Q;
         if (push_cs)                                csum_pend <= 1'b0;
         else if (rd_pend && pend_addr == LAST_A)    csum_pend <= 1'b1;
`endif
      end
   end
endmodule
